fm_zc_demod: RTL and testbench

// Receive-side counterpart of the DDS FM modulator. Recovers the DDS phase increment from a sampled

---
 rtl/fm_zc_demod.sv | 168 ++++++++++++++++
 tb/tb_fm_zc_demod.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fm_zc_demod.sv
// fm_zc_demod: zero-crossing FM demodulator.
// Measures the number of sample strobes between rising zero crossings (P) and
// recovers the DDS phase increment as 2^NBITS / P with a bit-serial restoring
// divider. A saturated period counter signals loss of input (no_signal).
// Optional feature macro: FM_ZC_DEMOD_AVG_EN -- when defined, each estimate is
// the mean of the new and the previous quotient (first one after acquisition
// is passed through unaveraged).
module fm_zc_demod #(
  parameter int NBITS        = 13,
  parameter int N_INPUT_BITS = 9,
  parameter int PERIOD_BITS  = 16,
  parameter int HYST         = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enableclk,
  input  logic signed [N_INPUT_BITS-1:0] insample,
  output logic        [NBITS-1:0]        phaseinc_est,
  output logic                           est_valid,
  output logic                           no_signal,
  output logic                           overrun
);

  localparam logic [PERIOD_BITS-1:0]         CNT_MAX = '1;
  localparam logic signed [N_INPUT_BITS-1:0] ARM_LVL = N_INPUT_BITS'(-HYST);
  localparam int                             IT_W    = $clog2(NBITS + 2);
  // NBITS+1 quotient bits: the dividend 2^NBITS is NBITS+1 bits wide
  localparam logic [IT_W-1:0]                IT_LAST = IT_W'(NBITS + 1);

  typedef enum logic [1:0] {ACQUIRE, MEASURE, DIVIDE} state_t;

  state_t                 state, state_nxt;
  logic                   armed;
  logic [PERIOD_BITS-1:0] count;
  logic [PERIOD_BITS-1:0] period;
  logic [PERIOD_BITS-1:0] rem;
  logic [PERIOD_BITS-1:0] rem_nxt;
  logic [PERIOD_BITS:0]   rem_sh;
  logic                   fits;
  logic [NBITS-1:0]       quo;
  logic [IT_W-1:0]        it_cnt;
  logic [NBITS-1:0]       est_next;

  logic crossing, arm_hit, timeout, div_start, div_busy, div_done;

  // Saturating period-counter increment; saturation is the no-signal marker
  function automatic logic [PERIOD_BITS-1:0] sat_inc(input logic [PERIOD_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Event decode. A crossing needs a prior arming sample, so P >= 2 always.
  // Timeout fires once: it is suppressed while already idling in ACQUIRE
  // with no_signal raised, and a crossing on the same strobe takes priority.
  assign crossing  = enableclk & armed & ~insample[N_INPUT_BITS-1];
  assign arm_hit   = enableclk & (insample < ARM_LVL);
  assign timeout   = enableclk & ~crossing & (count == CNT_MAX) &
                     ~((state == ACQUIRE) & no_signal);
  assign div_start = crossing & (state == MEASURE);
  assign div_busy  = (state == DIVIDE) & (it_cnt != IT_LAST);
  assign div_done  = (state == DIVIDE) & (it_cnt == IT_LAST) & ~timeout;

  // Restoring divide step: the only 1 in the dividend enters on the first step
  always_comb begin
    rem_sh  = {rem, (it_cnt == '0)};
    fits    = (rem_sh >= {1'b0, period});
    rem_nxt = fits ? (rem_sh[PERIOD_BITS-1:0] - period) : rem_sh[PERIOD_BITS-1:0];
  end

`ifdef FM_ZC_DEMOD_AVG_EN
  logic [NBITS-1:0] q_prev;
  logic             have_prev;

  // Mean of two quotients, summed one bit wider so the carry is kept
  function automatic logic [NBITS-1:0] avg2(input logic [NBITS-1:0] a,
                                            input logic [NBITS-1:0] b);
    logic [NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[NBITS:1];
  endfunction

  // Previous quotient; forgotten on timeout so re-acquisition starts clean
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_prev    <= '0;
      have_prev <= 1'b0;
    end else if (timeout) begin
      have_prev <= 1'b0;
    end else if (div_done) begin
      q_prev    <= quo;
      have_prev <= 1'b1;
    end
  end

  assign est_next = have_prev ? avg2(quo, q_prev) : quo;
`else
  assign est_next = quo;
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ACQUIRE;
    else        state <= state_nxt;
  end

  // Next-state logic; timeout overrides everything, aborting a divide
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACQUIRE: if (crossing) state_nxt = MEASURE;
      MEASURE: if (crossing) state_nxt = DIVIDE;
      DIVIDE:  if (div_done) state_nxt = MEASURE;
      default: state_nxt = ACQUIRE;
    endcase
    if (timeout) state_nxt = ACQUIRE;
  end

  // Arm/cross detector and period counter, advanced only on sample strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
      count <= PERIOD_BITS'(1);
    end else if (enableclk) begin
      if (crossing)     armed <= 1'b0;
      else if (arm_hit) armed <= 1'b1;
      count <= crossing ? PERIOD_BITS'(1) : sat_inc(count);
    end
  end

  // Bit-serial divider; runs every clock regardless of the sample strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period <= '0;
      rem    <= '0;
      quo    <= '0;
      it_cnt <= '0;
    end else if (div_start) begin
      period <= count;
      rem    <= '0;
      quo    <= '0;
      it_cnt <= '0;
    end else if (div_busy) begin
      rem    <= rem_nxt;
      quo    <= {quo[NBITS-2:0], fits};
      it_cnt <= it_cnt + 1'b1;
    end
  end

  // Output registers: estimate/no_signal hold between updates, pulses last one clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phaseinc_est <= '0;
      est_valid    <= 1'b0;
      no_signal    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      est_valid <= timeout | div_done;
      overrun   <= crossing & (state == DIVIDE);
      if (timeout) begin
        phaseinc_est <= '0;
        no_signal    <= 1'b1;
      end else if (div_done) begin
        phaseinc_est <= est_next;
        no_signal    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fm_zc_demod.sv
// tb_fm_zc_demod: randomized and directed bench for fm_zc_demod with a
// cycle-level reference model and an output scoreboard.
module tb_fm_zc_demod;
  localparam int NBITS = 13;
  localparam int NIB   = 9;
  localparam int PB    = 10;
  localparam int HYST  = 8;
  localparam int PMAX  = (1 << PB) - 1;
  localparam int LAT   = NBITS + 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  enableclk = 1'b0;
  logic signed [NIB-1:0] insample = '0;
  logic [NBITS-1:0]      phaseinc_est;
  logic                  est_valid, no_signal, overrun;

  fm_zc_demod #(.NBITS(NBITS), .N_INPUT_BITS(NIB), .PERIOD_BITS(PB), .HYST(HYST)) dut (
    .clock(clock), .reset(reset), .enableclk(enableclk), .insample(insample),
    .phaseinc_est(phaseinc_est), .est_valid(est_valid), .no_signal(no_signal),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct { int est; int ns; int due; } exp_t;
  exp_t sbq[$];
  exp_t mx;

  int n_checks = 0, n_pass = 0;
  int ov_act = 0, ov_exp = 0, ev_count = 0, last_est = 0;

  // reference model state
  int m_armed, m_cnt, m_acq, m_ns, m_busy_end, m_prev, m_have_prev;
  int ph = 0;
  int cur_smp = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_armed = 0; m_cnt = 1; m_acq = 0; m_ns = 0; m_busy_end = 0;
    m_prev = 0; m_have_prev = 0;
    sbq.delete();
  endtask

  // Drive one clock of input and advance the model for the edge that samples it
  task automatic step(int en, int smp);
    int e, q, est;
    bit cr;
    @(negedge clock);
    enableclk = en[0];
    insample  = NIB'(smp);
    cur_smp   = smp;
    e = cyc + 1;
    if (en != 0) begin
      cr = (m_armed != 0) && (smp >= 0);
      if (cr) m_armed = 0;
      else if (smp < -HYST) m_armed = 1;
      if (cr) begin
        if (m_acq == 0) m_acq = 1;
        else if (e <= m_busy_end) ov_exp++;
        else begin
          q = (1 << NBITS) / m_cnt;
          est = q;
`ifdef FM_ZC_DEMOD_AVG_EN
          if (m_have_prev != 0) est = (q + m_prev) / 2;
          m_prev = q;
          m_have_prev = 1;
`endif
          sbq.push_back('{est, 0, e + LAT});
          m_ns = 0;
          m_busy_end = e + LAT;
        end
        m_cnt = 1;
      end else if (m_cnt == PMAX && (m_acq != 0 || m_ns == 0)) begin
        if (e <= m_busy_end && sbq.size() > 0) sbq.delete(sbq.size() - 1);
        sbq.push_back('{0, 1, e});
        m_ns = 1; m_acq = 0; m_busy_end = 0; m_have_prev = 0;
      end else if (m_cnt < PMAX) begin
        m_cnt++;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, cur_smp);
  endtask

  // DDS sinusoid source: one strobe every div clocks
  task automatic dds(int inc, int nstrobes, int div);
    int s;
    for (int k = 0; k < nstrobes; k++) begin
      for (int d = 0; d < div - 1; d++) step(0, cur_smp);
      s = $rtoi(200.0 * $sin(2.0 * 3.14159265358979 * ph / 8192.0));
      step(1, s);
      ph = (ph + inc) % 8192;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      if (overrun) ov_act++;
      if (est_valid) begin
        ev_count++;
        last_est = int'(phaseinc_est);
        if (sbq.size() == 0) check("unexpected_est_valid", 1, 0);
        else begin
          mx = sbq.pop_front();
          check("est_value", int'(phaseinc_est), mx.est);
          check("est_no_signal", int'(no_signal), mx.ns);
          check("est_cycle", cyc, mx.due);
        end
      end
    end
  end

  initial begin
    int evc0, ov0, len, mag;
    model_reset();
    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_est", int'(phaseinc_est), 0);
    check("rst_valid", int'(est_valid), 0);
    check("rst_no_signal", int'(no_signal), 0);
    check("rst_overrun", int'(overrun), 0);
    @(negedge clock);
    reset = 1'b1;

    // lock on phaseinc 64, strobe every 4 clocks
    dds(64, 5 * 128, 4);
    idle(30);
    check("lock64_est", last_est, 64);
    check("lock64_no_signal", int'(no_signal), 0);

    // frequency step to 128
    dds(128, 6 * 64, 4);
    idle(30);
    check("step128_est", last_est, 128);

    // noise inside the hysteresis band: no crossings
    step(1, 0);
    idle(30);
    evc0 = ev_count;
    for (int i = 0; i < 300; i++) step(1, int'($urandom_range(0, 2 * HYST)) - HYST);
    idle(30);
    check("noise_no_est", ev_count - evc0, 0);

    // constant zero until timeout
    for (int i = 0; i < PMAX + 50; i++) step(1, 0);
    idle(5);
    check("timeout_no_signal", int'(no_signal), 1);
    check("timeout_est", int'(phaseinc_est), 0);

    // random square-ish waves with random periods and strobe gaps
    for (int p = 0; p < 80; p++) begin
      len = int'($urandom_range(2, 40));
      for (int i = 0; i < len; i++) begin
        mag = int'($urandom_range(0, 60));
        if ($urandom_range(0, 3) == 0) step(0, cur_smp);
        step(1, (i < len / 2) ? -(mag + 1) : (mag - 10));
      end
    end
    for (int i = 0; i < 400; i++) step(int'($urandom_range(0, 1)), int'($urandom_range(0, 60)) - 30);
    idle(30);

    // P=2 at full strobe rate: divider busy, overruns
    ov0 = ov_act;
    for (int i = 0; i < 60; i++) step(1, (i % 2 == 0) ? -20 : 20);
    idle(30);
    check("p2_est", last_est, 4096);
    check("p2_overrun_seen", int'(ov_act > ov0), 1);
    check("p2_overrun_count", ov_act, ov_exp);

    // async reset in the middle of a divide
    step(1, -20);
    step(1, 20);
    idle(5);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    check("midreset_est", int'(phaseinc_est), 0);
    check("midreset_valid", int'(est_valid), 0);
    check("midreset_no_signal", int'(no_signal), 0);
    check("midreset_overrun", int'(overrun), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    evc0 = ev_count;
    ph = 0;
    dds(64, 129, 1);
    idle(30);
    check("post_reset_first_cross_no_est", ev_count - evc0, 0);
    dds(64, 128, 1);
    idle(30);
    check("post_reset_est", last_est, 64);

    idle(30);
    check("scoreboard_drained", sbq.size(), 0);
    check("overrun_total", ov_act, ov_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
